// File: rtl/ir_key_event.sv
// Turns the demodulator's SIRC frame stream into press / repeat / release key events,
// buffered in a 4-deep first-word-fall-through FIFO with a valid/ready pop side.
module ir_key_event #(
    parameter bit         ADDR_MATCH_EN = 1'b0,
    parameter logic [4:0] ADDR_FILTER   = 5'd1,
    parameter int         RELEASE_TICKS = 6000,
    parameter int         REPEAT_DELAY  = 3,
    parameter int         REPEAT_RATE   = 2
) (
    input  logic        RST,
    input  logic        OutClk,
    input  logic [11:0] code_in,
    input  logic [31:0] code_cnt,
    input  logic        evt_ready,
    output logic        evt_valid,
    output logic [1:0]  evt_type,
    output logic [4:0]  evt_addr,
    output logic [6:0]  evt_cmd,
    output logic        key_held,
    output logic [6:0]  held_cmd,
    output logic [2:0]  fifo_level,
    output logic [7:0]  drop_cnt
);
    localparam int            TW        = (RELEASE_TICKS > 1) ? $clog2(RELEASE_TICKS) : 1;
    localparam logic [TW-1:0] TIMEOUT   = TW'(RELEASE_TICKS - 1);
    localparam logic [31:0]   FIRST_REP = 32'(REPEAT_DELAY + 1);
    localparam logic [31:0]   REP_RATE  = 32'(REPEAT_RATE);
    localparam logic [1:0]    EV_PRESS   = 2'b01;
    localparam logic [1:0]    EV_REPEAT  = 2'b10;
    localparam logic [1:0]    EV_RELEASE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [31:0]   last_cnt;
    logic [4:0]    held_addr;
    logic [7:0]    frame_n;
    logic [TW-1:0] timer;

    logic [4:0]    rx_addr;
    logic [6:0]    rx_cmd;
    logic          frame_new, frame_acc, same_key, timeout;
    logic [7:0]    frame_n_inc;
    logic [31:0]   frame_n_ext;
    logic          repeat_hit;

    logic          push;
    logic [13:0]   push_data;

    // SIRC is transmitted LSB first, so the word arrives bit-reversed.
    always_comb begin
        rx_cmd  = '0;
        rx_addr = '0;
        for (int i = 0; i < 7; i++) rx_cmd[i] = code_in[11-i];
        for (int j = 0; j < 5; j++) rx_addr[j] = code_in[4-j];
    end

    assign frame_new   = (code_cnt != last_cnt) && (state != ST_SWITCH);
    assign frame_acc   = frame_new && (!ADDR_MATCH_EN || (rx_addr == ADDR_FILTER));
    assign same_key    = ({rx_addr, rx_cmd} == {held_addr, held_cmd});
    assign timeout     = (timer == TIMEOUT);
    assign frame_n_inc = (frame_n == 8'hFF) ? frame_n : frame_n + 8'd1;
    assign frame_n_ext = {24'd0, frame_n_inc};
    assign repeat_hit  = (frame_n_ext >= FIRST_REP) &&
                         (((frame_n_ext - FIRST_REP) % REP_RATE) == 32'd0);

    always_ff @(posedge OutClk or negedge RST) begin
        if (!RST) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (frame_acc) state_nxt = ST_HELD;
            ST_HELD: begin
                if (frame_acc) begin
                    if (!same_key) state_nxt = ST_SWITCH;
                end else if (timeout) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SWITCH: state_nxt = ST_HELD;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // An accepted frame on the timeout edge takes priority, so no release is pushed then.
    always_comb begin
        push      = 1'b0;
        push_data = '0;
        case (state)
            ST_IDLE: begin
                if (frame_acc) begin
                    push      = 1'b1;
                    push_data = {EV_PRESS, rx_addr, rx_cmd};
                end
            end
            ST_HELD: begin
                if (frame_acc) begin
                    if (same_key) begin
                        push      = repeat_hit;
                        push_data = {EV_REPEAT, held_addr, held_cmd};
                    end else begin
                        push      = 1'b1;
                        push_data = {EV_RELEASE, held_addr, held_cmd};
                    end
                end else if (timeout) begin
                    push      = 1'b1;
                    push_data = {EV_RELEASE, held_addr, held_cmd};
                end
            end
            ST_SWITCH: begin
                push      = 1'b1;
                push_data = {EV_PRESS, held_addr, held_cmd};
            end
            default: begin
                push      = 1'b0;
                push_data = '0;
            end
        endcase
    end

    assign key_held = (state != ST_IDLE);

    always_ff @(posedge OutClk or negedge RST) begin
        if (!RST) begin
            last_cnt  <= '0;
            held_addr <= '0;
            held_cmd  <= '0;
            frame_n   <= '0;
            timer     <= '0;
        end else begin
            if (frame_new) last_cnt <= code_cnt;
            case (state)
                ST_IDLE: begin
                    if (frame_acc) begin
                        held_addr <= rx_addr;
                        held_cmd  <= rx_cmd;
                        frame_n   <= 8'd1;
                        timer     <= '0;
                    end
                end
                ST_HELD: begin
                    if (frame_acc) begin
                        if (same_key) begin
                            frame_n <= frame_n_inc;
                            timer   <= '0;
                        end else begin
                            held_addr <= rx_addr;
                            held_cmd  <= rx_cmd;
                        end
                    end else if (timeout) begin
                        held_addr <= '0;
                        held_cmd  <= '0;
                        frame_n   <= '0;
                        timer     <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                ST_SWITCH: begin
                    frame_n <= 8'd1;
                    timer   <= '0;
                end
                default: begin
                    timer <= '0;
                end
            endcase
        end
    end

    logic [13:0] mem [0:3];
    logic [1:0]  wr_ptr, rd_ptr;
    logic        pop, full, push_ok, drop;

    assign evt_valid = (fifo_level != 3'd0);
    assign pop       = evt_valid && evt_ready;
    assign full      = (fifo_level == 3'd4);
    assign push_ok   = push && (!full || pop);
    assign drop      = push && full && !pop;
    assign {evt_type, evt_addr, evt_cmd} = evt_valid ? mem[rd_ptr] : 14'd0;

    always_ff @(posedge OutClk or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 4; i++) mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            drop_cnt   <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            case ({push_ok, pop})
                2'b10:   fifo_level <= fifo_level + 3'd1;
                2'b01:   fifo_level <= fifo_level - 3'd1;
                default: fifo_level <= fifo_level;
            endcase
            if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_ir_key_event.sv
// Bench for ir_key_event: two instances (default and filtered/short-timeout) checked
// every edge against a timestamp-based event model, plus directed scenario checks.
module tb_ir_key_event;
    logic        RST, OutClk;
    logic [11:0] code_in;
    logic [31:0] code_cnt;
    logic        ready0, ready1;

    logic        o0_valid, o1_valid, o0_held, o1_held;
    logic [1:0]  o0_type, o1_type;
    logic [4:0]  o0_addr, o1_addr;
    logic [6:0]  o0_cmd, o1_cmd, o0_hcmd, o1_hcmd;
    logic [2:0]  o0_level, o1_level;
    logic [7:0]  o0_drop, o1_drop;

    ir_key_event dut0 (
        .RST(RST), .OutClk(OutClk), .code_in(code_in), .code_cnt(code_cnt),
        .evt_ready(ready0), .evt_valid(o0_valid), .evt_type(o0_type),
        .evt_addr(o0_addr), .evt_cmd(o0_cmd), .key_held(o0_held),
        .held_cmd(o0_hcmd), .fifo_level(o0_level), .drop_cnt(o0_drop)
    );

    ir_key_event #(
        .ADDR_MATCH_EN(1'b1), .ADDR_FILTER(5'd1), .RELEASE_TICKS(20),
        .REPEAT_DELAY(2), .REPEAT_RATE(3)
    ) dut1 (
        .RST(RST), .OutClk(OutClk), .code_in(code_in), .code_cnt(code_cnt),
        .evt_ready(ready1), .evt_valid(o1_valid), .evt_type(o1_type),
        .evt_addr(o1_addr), .evt_cmd(o1_cmd), .key_held(o1_held),
        .held_cmd(o1_hcmd), .fifo_level(o1_level), .drop_cnt(o1_drop)
    );

    initial OutClk = 1'b0;
    always #5 OutClk = ~OutClk;

    // Scoreboard: entries tagged with the instance number in bit 14.
    logic [14:0] exp_q[$];
    logic        m_held [2];
    logic [11:0] m_key  [2];
    int          m_n    [2];
    int          m_last [2];
    logic        m_sw   [2];
    logic [31:0] m_cnt  [2];
    int          m_drop [2];
    int          cyc, n_pass, n_checks;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [11:0] enc(input logic [4:0] a, input logic [6:0] c);
        logic [11:0] w = '0;
        for (int i = 0; i < 7; i++) w[11-i] = c[i];
        for (int j = 0; j < 5; j++) w[4-j] = a[j];
        return w;
    endfunction

    function automatic int q_count(input int k);
        int n = 0;
        foreach (exp_q[i]) if (exp_q[i][14] == k[0]) n++;
        return n;
    endfunction

    function automatic logic [13:0] q_head(input int k);
        logic [13:0] h = '0;
        logic found = 1'b0;
        foreach (exp_q[i]) begin
            if (!found && exp_q[i][14] == k[0]) begin
                h = exp_q[i][13:0];
                found = 1'b1;
            end
        end
        return h;
    endfunction

    task automatic q_pop(input int k);
        int idx = -1;
        foreach (exp_q[i]) if (idx < 0 && exp_q[i][14] == k[0]) idx = i;
        if (idx >= 0) exp_q.delete(idx);
    endtask

    task automatic push_evt(input int k, input logic [13:0] ev);
        if (q_count(k) < 4) exp_q.push_back({k[0], ev});
        else if (m_drop[k] < 255) m_drop[k]++;
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int k = 0; k < 2; k++) begin
            m_held[k] = 1'b0; m_key[k] = '0; m_n[k] = 0; m_last[k] = 0;
            m_sw[k] = 1'b0; m_cnt[k] = '0; m_drop[k] = 0;
        end
    endtask

    // Release is due RELEASE_TICKS edges after the last accepted frame.
    task automatic model_edge(input int k);
        logic [4:0] a;
        logic [6:0] c;
        logic acc, rdy, filt_en;
        int rd, rr, rt;
        rdy     = (k == 0) ? ready0 : ready1;
        rd      = (k == 0) ? 3 : 2;
        rr      = (k == 0) ? 2 : 3;
        rt      = (k == 0) ? 6000 : 20;
        filt_en = (k == 1);
        a = '0;
        c = '0;
        for (int i = 0; i < 7; i++) c[i] = code_in[11-i];
        for (int j = 0; j < 5; j++) a[j] = code_in[4-j];
        if (rdy && q_count(k) > 0) q_pop(k);
        if (m_sw[k]) begin
            push_evt(k, {2'b01, m_key[k]});
            m_n[k] = 1; m_last[k] = cyc; m_sw[k] = 1'b0;
        end else begin
            acc = 1'b0;
            if (code_cnt != m_cnt[k]) begin
                m_cnt[k] = code_cnt;
                acc = !filt_en || (a == 5'd1);
            end
            if (acc) begin
                if (!m_held[k]) begin
                    push_evt(k, {2'b01, a, c});
                    m_held[k] = 1'b1; m_key[k] = {a, c}; m_n[k] = 1; m_last[k] = cyc;
                end else if ({a, c} == m_key[k]) begin
                    if (m_n[k] < 255) m_n[k]++;
                    m_last[k] = cyc;
                    if (m_n[k] >= rd + 1 && (m_n[k] - rd - 1) % rr == 0)
                        push_evt(k, {2'b10, m_key[k]});
                end else begin
                    push_evt(k, {2'b11, m_key[k]});
                    m_key[k] = {a, c}; m_sw[k] = 1'b1;
                end
            end else if (m_held[k] && (cyc - m_last[k] == rt)) begin
                push_evt(k, {2'b11, m_key[k]});
                m_held[k] = 1'b0;
            end
        end
    endtask

    function automatic logic [63:0] obs_vec(input int k);
        if (k == 0)
            return {30'd0, o0_valid, o0_type, o0_addr, o0_cmd, o0_held, o0_hcmd, o0_level, o0_drop};
        return {30'd0, o1_valid, o1_type, o1_addr, o1_cmd, o1_held, o1_hcmd, o1_level, o1_drop};
    endfunction

    function automatic logic [63:0] exp_vec(input int k);
        int n = q_count(k);
        logic [13:0] h = q_head(k);
        logic [6:0] hc = m_held[k] ? m_key[k][6:0] : 7'd0;
        return {30'd0, (n > 0), h, m_held[k], hc, 3'(n), 8'(m_drop[k])};
    endfunction

    task automatic step();
        @(posedge OutClk);
        if (RST) begin
            model_edge(0);
            model_edge(1);
        end
        cyc++;
        #1;
        chk("edge_dut0", obs_vec(0), exp_vec(0));
        chk("edge_dut1", obs_vec(1), exp_vec(1));
    endtask

    int f_cyc, rel_cyc, gap;
    logic rel_seen;
    logic [4:0] ra;
    logic [6:0] rc;

    initial begin
        n_pass = 0; n_checks = 0; cyc = 0;
        RST = 1'b0; code_in = '0; code_cnt = '0; ready0 = 1'b0; ready1 = 1'b0;
        model_reset();
        repeat (3) step();
        chk("rst_valid", o0_valid, 0);
        chk("rst_head", {o0_type, o0_addr, o0_cmd}, 0);
        chk("rst_held", {o0_held, o0_hcmd}, 0);
        chk("rst_level_drop", {o0_level, o0_drop}, 0);
        RST = 1'b1;
        step();

        // Single press frame.
        code_in = 12'h481; code_cnt = 32'd1;
        step();
        f_cyc = cyc;
        chk("t1_valid", o0_valid, 1);
        chk("t1_type", o0_type, 2'b01);
        chk("t1_cmd", o0_cmd, 7'h12);
        chk("t1_addr", o0_addr, 5'h10);
        chk("t1_held", o0_held, 1);

        // Six identical frames 4500 ticks apart, popping as events appear.
        ready0 = 1'b1;
        step();
        chk("t2_press_popped", o0_valid, 0);
        for (int f = 2; f <= 6; f++) begin
            while (cyc < f_cyc + 4499) step();
            code_cnt = code_cnt + 1;
            step();
            f_cyc = cyc;
            chk($sformatf("t2_frame%0d_evt", f), {o0_valid, o0_type},
                (f == 4 || f == 6) ? 3'b110 : 3'b000);
        end
        rel_seen = 1'b0; rel_cyc = 0;
        for (int t = 0; t < 7000 && !rel_seen; t++) begin
            step();
            if (o0_valid && o0_type == 2'b11) begin
                rel_seen = 1'b1;
                rel_cyc = cyc;
            end
        end
        chk("t2_release_seen", rel_seen, 1);
        chk("t2_release_delay", 64'(rel_cyc - f_cyc), 6000);
        chk("t2_release_cmd", o0_cmd, 7'h12);
        chk("t2_key_released", {o0_held, o0_hcmd}, 0);
        step();
        ready0 = 1'b0;

        // Key switch: release of old key on detect edge, press of new one edge later.
        code_in = enc(5'h10, 7'h12); code_cnt = code_cnt + 1;
        step();
        chk("t3_press", {o0_type, o0_cmd}, {2'b01, 7'h12});
        ready0 = 1'b1; step(); ready0 = 1'b0;
        repeat (3) step();
        code_in = enc(5'h10, 7'h13); code_cnt = code_cnt + 1;
        step();
        chk("t3_rel_head", {o0_type, o0_addr, o0_cmd}, {2'b11, 5'h10, 7'h12});
        chk("t3_rel_level", o0_level, 1);
        chk("t3_held_switch", o0_held, 1);
        step();
        chk("t3_press_level", o0_level, 2);
        chk("t3_held_cmd", {o0_held, o0_hcmd}, {1'b1, 7'h13});
        ready0 = 1'b1;
        step();
        chk("t3_press_head", {o0_type, o0_cmd}, {2'b01, 7'h13});
        step();
        ready0 = 1'b0;
        chk("t3_drained", o0_level, 0);

        // Reset while held with two events queued.
        code_in = enc(5'h10, 7'h14); code_cnt = code_cnt + 1;
        step(); step();
        chk("t6_queued", {o0_held, o0_level}, {1'b1, 3'd2});
        #2;
        RST = 1'b0; code_cnt = '0;
        #1;
        model_reset();
        chk("t6_async_dut0", obs_vec(0), 0);
        chk("t6_async_dut1", obs_vec(1), 0);
        repeat (2) step();
        RST = 1'b1;
        repeat (6100) step();
        chk("t6_no_release", {o0_valid, o0_level, o0_held}, 0);

        // FIFO overflow and push-with-pop at full.
        code_in = enc(5'h10, 7'h2A);
        for (int f = 1; f <= 12; f++) begin
            code_cnt = code_cnt + 1;
            step();
            repeat (2) step();
        end
        chk("t5_full_level", o0_level, 4);
        chk("t5_drop", o0_drop, 2);
        chk("t5_head", {o0_type, o0_cmd}, {2'b01, 7'h2A});
        code_cnt = code_cnt + 1;
        step(); repeat (2) step();
        ready0 = 1'b1; code_cnt = code_cnt + 1;
        step();
        ready0 = 1'b0;
        chk("t5_pushpop_level", o0_level, 4);
        chk("t5_pushpop_drop", o0_drop, 2);
        chk("t5_pushpop_head", o0_type, 2'b10);
        ready0 = 1'b1; repeat (5) step(); ready0 = 1'b0;

        // Address filter on dut1.
        code_in = enc(5'd2, 7'h05); code_cnt = code_cnt + 1;
        step(); step();
        chk("t4_filtered", {o1_valid, o1_level}, 0);
        code_in = enc(5'd1, 7'h05); code_cnt = code_cnt + 1;
        step();
        chk("t4_accept", {o1_valid, o1_type, o1_addr, o1_cmd}, {1'b1, 2'b01, 5'd1, 7'h05});

        // Randomized frame stream with random back-pressure.
        ra = 5'd1; rc = 7'h05;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0:       ra = 5'd1;
                    1:       ra = 5'h10;
                    default: ra = 5'($urandom_range(0, 31));
                endcase
                rc = ($urandom_range(0, 1) == 0) ? 7'h12 : 7'($urandom_range(0, 127));
            end
            code_in = enc(ra, rc);
            if (n == 200) code_cnt = 32'hFFFF_FFFF;
            else if ($urandom_range(0, 7) == 0) code_cnt = code_cnt + 32'($urandom_range(2, 1000000));
            else code_cnt = code_cnt + 1;
            gap = $urandom_range(1, 25);
            for (int g = 0; g < gap; g++) begin
                ready0 = ($urandom_range(0, 3) != 0);
                ready1 = ($urandom_range(0, 3) != 0);
                step();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ir_key_event.md
Name: ir_key_event

Overview:
- Downstream consumer of the IR demodulator's received-frame registers: the 12-bit code word and the running frame count.
- Turns the raw SIRC frame stream into debounced key events: press, auto-repeat and release.
- Applies an optional device-address filter.
- Buffers events in a 4-entry FIFO with a valid/ready pop interface, for the AXI-lite register front end or a local controller.

Parameters:
ADDR_MATCH_EN, 0, 1 = accept only frames whose address equals ADDR_FILTER
ADDR_FILTER, 5'd1, accepted device address when filtering is enabled
RELEASE_TICKS, 6000, OutClk ticks with no accepted frame before release (60 ms at 100 kHz)
REPEAT_DELAY, 3, identical frames after press before the first repeat
REPEAT_RATE, 2, identical frames between subsequent repeats (>=1)

Ports:
RST  in  1  asynchronous active-low reset
OutClk  in  1  block clock (100 kHz)
code_in  in  12  last received frame word, first-received bit in bit 11
code_cnt  in  32  frame counter; a change marks a new frame, with code_in valid in that cycle
evt_ready  in  1  consumer accepts the head event
evt_valid  out  1  FIFO non-empty
evt_type  out  2  head event: 01 press, 10 repeat, 11 release
evt_addr  out  5  head event address
evt_cmd  out  7  head event command
key_held  out  1  a key is currently held
held_cmd  out  7  command of the held key (0 when idle)
fifo_level  out  3  entries in FIFO, 0..4
drop_cnt  out  8  events lost to FIFO full, saturating at 255

Behaviour:
- Reset: RST is asynchronous and active-low; the block is clocked by OutClk. Reset clears everything:
  - evt_valid=0, evt_type/addr/cmd=0, key_held=0, held_cmd=0, fifo_level=0, drop_cnt=0.
  - Internal last_cnt=0, FSM=IDLE, all timers=0.
  - Reset mid-hold emits no release event.
- Frame detect: on an edge where code_cnt != last_cnt (and FSM != SWITCH), last_cnt<=code_cnt and code_in is decoded.
- Decode: SIRC is sent LSB first.
  - cmd[i]=code_in[11-i] for i=0..6.
  - addr[j]=code_in[4-j] for j=0..4.
- Filter: if ADDR_MATCH_EN=1 and addr!=ADDR_FILTER, the frame is consumed (last_cnt updated) but ignored entirely; it does not reset the release timer.
- FSM:
  - IDLE: an accepted frame pushes press{cmd,addr}. Load held key, frame_n<=1, timer<=0, go to HELD.
  - HELD, accepted frame with the same cmd and addr:
    - timer<=0, frame_n<=frame_n+1 (saturating at 255).
    - Push repeat when new frame_n >= REPEAT_DELAY+1 and (frame_n-REPEAT_DELAY-1) mod REPEAT_RATE == 0. With defaults, repeats occur at frames 4, 6, 8, ...
  - HELD, accepted frame with a different key: push release of the old key, latch the new key, go to SWITCH.
  - HELD, no frame: timer++. When timer==RELEASE_TICKS-1, push release, key_held<=0, held_cmd<=0, go to IDLE.
  - A frame arriving on the same edge as the timeout wins: the timer resets and no release is pushed.
  - SWITCH (exactly 1 cycle): push press of the latched key, frame_n<=1, timer<=0, go to HELD. Frame detect is blocked in SWITCH; a pending code_cnt change is caught on the following edge.
- key_held=1 in HELD and SWITCH. held_cmd tracks the current held key.
- Latency: an event is written on the detect edge and is visible on evt_* after that edge. The SWITCH press follows one edge later.
- FIFO:
  - 4 entries of 14 bits {type,addr,cmd}, first-word-fall-through; evt_* show the head.
  - Pop on evt_valid & evt_ready.
  - Push when full: the event is dropped and drop_cnt++ (saturating). If a pop happens on the same edge as a push while full, the push is accepted and the level stays 4.
  - Simultaneous push and pop at other levels leaves the level unchanged.
  - evt_* hold their value while evt_ready=0. When the FIFO is empty, evt_type/addr/cmd=0.
- Width rules: timer is wide enough for RELEASE_TICKS. The code_cnt compare uses all 32 bits, so wrap-around is just another change.

Test Plan:
- Reset, then one frame code_in=12'h481 (cmd=0x12, addr=0x10, no filter), code_cnt 0->1 -> evt_valid=1, type=01, cmd=0x12, addr=0x10; key_held=1.
- Six identical frames 4500 ticks apart, then silence -> FIFO events press, repeat (frame 4), repeat (frame 6), then release exactly 6000 ticks after the last frame; key_held=0. Pop each event as it appears.
- Held cmd 0x12, then a frame with cmd 0x13 -> release(0x12) on the detect edge, press(0x13) one edge later; key_held stays 1.
- ADDR_MATCH_EN=1, ADDR_FILTER=1, frame with addr 2 -> no event, fifo_level=0. Then an addr-1 frame -> press.
- evt_ready=0 while generating 6 events -> fifo_level=4, drop_cnt=2. A push coinciding with a pop at full -> level stays 4, drop_cnt unchanged.
- Assert RST while held with 2 events queued -> all outputs 0 immediately; no release appears after RST is deasserted.
